video_timing_generator: RTL and testbench



---
 rtl/video_timing_generator.sv | 152 +++++++++++++++
 tb/tb_video_timing_generator.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/video_timing_generator.sv
// Raster timing generator for the SXGA060 OLED test-image path.
// Emits registered x/y/DE/HSync/VSync/FrameStart from a blanking-first
// hc/vc scan, plus a one-hot ImageState that rotates on frame boundaries
// (auto-advance every FRAMES_PER_IMAGE frames, or on a NextImage request).
module video_timing_generator #(
    parameter int WIDTH            = 1280,
    parameter int HEIGHT           = 1024,
    parameter int H_FP             = 48,
    parameter int H_SYNC           = 112,
    parameter int H_BP             = 248,
    parameter int V_FP             = 1,
    parameter int V_SYNC           = 3,
    parameter int V_BP             = 38,
    parameter int FRAMES_PER_IMAGE = 120
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Hold,
    input  logic        NextImage,
    output logic [11:0] x,
    output logic [11:0] y,
    output logic        DE,
    output logic        HSync,
    output logic        VSync,
    output logic        FrameStart,
    output logic [3:0]  ImageState
);

    localparam logic [11:0] H_BLANK = 12'(H_FP + H_SYNC + H_BP);
    localparam logic [11:0] H_LAST  = 12'(H_FP + H_SYNC + H_BP + WIDTH - 1);
    localparam logic [11:0] V_BLANK = 12'(V_FP + V_SYNC + V_BP);
    localparam logic [11:0] V_LAST  = 12'(V_FP + V_SYNC + V_BP + HEIGHT - 1);
    localparam logic [11:0] HS_BEG  = 12'(H_FP);
    localparam logic [11:0] HS_END  = 12'(H_FP + H_SYNC);
    localparam logic [11:0] VS_BEG  = 12'(V_FP);
    localparam logic [11:0] VS_END  = 12'(V_FP + V_SYNC);
    localparam logic [11:0] FC_LAST = 12'(FRAMES_PER_IMAGE - 1);
    localparam logic [11:0] BLANK   = 12'hfff;

    // Scan and image-select state
    logic [11:0] hc_q, hc_d;
    logic [11:0] vc_q, vc_d;
    logic [11:0] fc_q, fc_d;
    logic        pend_q, pend_d;
    logic [3:0]  img_q, img_d;

    // Output registers
    logic [11:0] x_q, x_d;
    logic [11:0] y_q, y_d;
    logic        de_q, de_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        fs_q, fs_d;
    logic [3:0]  ims_q;

    logic h_act, v_act, h_last, v_last, boundary, req;
    logic [3:0] img_rot;

    // Next-state for the scan counters, outputs and image rotation
    always_comb begin
        h_act    = (hc_q >= H_BLANK);
        v_act    = (vc_q >= V_BLANK);
        h_last   = (hc_q == H_LAST);
        v_last   = (vc_q == V_LAST);
        boundary = h_last && v_last;
        // A request arriving on the boundary cycle itself still counts.
        req      = pend_q || NextImage;
        img_rot  = {img_q[2:0], img_q[3]};

        // y holds through the leading horizontal blanking of each active line
        // so the pattern generator can precompute its gray level.
        y_d  = v_act ? (vc_q - V_BLANK) : BLANK;
        x_d  = (h_act && v_act) ? (hc_q - H_BLANK) : BLANK;
        de_d = h_act && v_act;
        hs_d = (hc_q >= HS_BEG) && (hc_q < HS_END);
        vs_d = (vc_q >= VS_BEG) && (vc_q < VS_END);
        fs_d = (hc_q == 12'd0) && (vc_q == 12'd0);

        hc_d = h_last ? 12'd0 : (hc_q + 12'd1);
        vc_d = vc_q;
        if (h_last) begin
            vc_d = v_last ? 12'd0 : (vc_q + 12'd1);
        end

        img_d  = img_q;
        fc_d   = fc_q;
        pend_d = req;
        if (boundary) begin
            if (req) begin
                // Request and auto-advance together still yield one step.
                img_d  = img_rot;
                fc_d   = 12'd0;
                pend_d = 1'b0;
            end else if (fc_q == FC_LAST) begin
                if (!Hold) begin
                    img_d = img_rot;
                    fc_d  = 12'd0;
                end
            end else begin
                fc_d = fc_q + 12'd1;
            end
        end
    end

    // Scan counters, frame counter, pending request and current image
    always_ff @(posedge Clock) begin
        if (Reset) begin
            hc_q   <= 12'd0;
            vc_q   <= 12'd0;
            fc_q   <= 12'd0;
            pend_q <= 1'b0;
            img_q  <= 4'b0001;
        end else begin
            hc_q   <= hc_d;
            vc_q   <= vc_d;
            fc_q   <= fc_d;
            pend_q <= pend_d;
            img_q  <= img_d;
        end
    end

    // Output registers; ImageState lags img_q one cycle so a new image
    // appears together with FrameStart.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            x_q   <= BLANK;
            y_q   <= BLANK;
            de_q  <= 1'b0;
            hs_q  <= 1'b0;
            vs_q  <= 1'b0;
            fs_q  <= 1'b0;
            ims_q <= 4'b0001;
        end else begin
            x_q   <= x_d;
            y_q   <= y_d;
            de_q  <= de_d;
            hs_q  <= hs_d;
            vs_q  <= vs_d;
            fs_q  <= fs_d;
            ims_q <= img_q;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign DE         = de_q;
    assign HSync      = hs_q;
    assign VSync      = vs_q;
    assign FrameStart = fs_q;
    assign ImageState = ims_q;

endmodule

// File: tb/tb_video_timing_generator.sv
// Directed bench for video_timing_generator with a tiny 14x7 raster.
module tb_video_timing_generator;

    localparam int FRAME = 98;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Hold;
    logic        NextImage;
    logic [11:0] x;
    logic [11:0] y;
    logic        DE;
    logic        HSync;
    logic        VSync;
    logic        FrameStart;
    logic [3:0]  ImageState;

    int checks   = 0;
    int failures = 0;

    video_timing_generator #(
        .WIDTH(8), .HEIGHT(4), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_FP(1), .V_SYNC(1), .V_BP(1), .FRAMES_PER_IMAGE(2)
    ) dut (
        .Clock(Clock), .Reset(Reset), .Hold(Hold), .NextImage(NextImage),
        .x(x), .y(y), .DE(DE), .HSync(HSync), .VSync(VSync),
        .FrameStart(FrameStart), .ImageState(ImageState)
    );

    always #5 Clock = ~Clock;

    typedef struct {
        int          cyc;
        logic [11:0] x;
        logic [11:0] y;
        logic        de;
        logic        hs;
        logic        vs;
        logic        fs;
    } vec_t;

    vec_t tbl[16];

    logic [11:0] sx[FRAME];
    logic [11:0] sy[FRAME];
    logic        sde[FRAME];
    logic        shs[FRAME];
    logic        svs[FRAME];
    logic        sfs[FRAME];
    logic [3:0]  simg[FRAME];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic setv(input int i, input int c, input logic [11:0] ex, input logic [11:0] ey,
                        input logic ede, input logic ehs, input logic evs, input logic efs);
        tbl[i].cyc = c;
        tbl[i].x   = ex;
        tbl[i].y   = ey;
        tbl[i].de  = ede;
        tbl[i].hs  = ehs;
        tbl[i].vs  = evs;
        tbl[i].fs  = efs;
    endtask

    // Runs one full frame starting with its (0,0) output cycle; NextImage is
    // pulsed on steps p1/p2 (1..98). Returns the image shown in that frame.
    task automatic run_frame(input string nm, input logic hold_v, input int p1, input int p2,
                             output logic [3:0] img);
        int extra_fs;
        int img_chg;
        extra_fs = 0;
        img_chg  = 0;
        img      = 4'bx;
        Hold     = hold_v;
        for (int k = 1; k <= FRAME; k++) begin
            NextImage = (k == p1) || (k == p2);
            step();
            if (k == 1) begin
                chk({nm, "_fs_first"}, 32'(FrameStart), 32'd1);
                img = ImageState;
            end else begin
                if (FrameStart) extra_fs++;
                if (ImageState !== img) img_chg++;
            end
        end
        NextImage = 1'b0;
        chk({nm, "_fs_extra"}, 32'(extra_fs), 32'd0);
        chk({nm, "_img_stable"}, 32'(img_chg), 32'd0);
    endtask

    logic [3:0] img;
    logic [3:0] free_exp[1:8];

    initial begin
        int de_n, fs_n, hs_n, vs_n, xsum, ysum, de_bad, y_lead, img_ok;

        setv(0,  0,  12'hfff, 12'hfff, 0, 0, 0, 1);
        setv(1,  2,  12'hfff, 12'hfff, 0, 1, 0, 0);
        setv(2,  3,  12'hfff, 12'hfff, 0, 1, 0, 0);
        setv(3,  4,  12'hfff, 12'hfff, 0, 0, 0, 0);
        setv(4,  6,  12'hfff, 12'hfff, 0, 0, 0, 0);
        setv(5,  14, 12'hfff, 12'hfff, 0, 0, 1, 0);
        setv(6,  16, 12'hfff, 12'hfff, 0, 1, 1, 0);
        setv(7,  27, 12'hfff, 12'hfff, 0, 0, 1, 0);
        setv(8,  28, 12'hfff, 12'hfff, 0, 0, 0, 0);
        setv(9,  42, 12'hfff, 12'h000, 0, 0, 0, 0);
        setv(10, 47, 12'hfff, 12'h000, 0, 0, 0, 0);
        setv(11, 48, 12'h000, 12'h000, 1, 0, 0, 0);
        setv(12, 55, 12'h007, 12'h000, 1, 0, 0, 0);
        setv(13, 56, 12'hfff, 12'h001, 0, 0, 0, 0);
        setv(14, 62, 12'h000, 12'h001, 1, 0, 0, 0);
        setv(15, 97, 12'h007, 12'h003, 1, 0, 0, 0);

        free_exp[1] = 4'b0001; free_exp[2] = 4'b0010; free_exp[3] = 4'b0010;
        free_exp[4] = 4'b0100; free_exp[5] = 4'b0100; free_exp[6] = 4'b1000;
        free_exp[7] = 4'b1000; free_exp[8] = 4'b0001;

        Reset = 1'b1; Hold = 1'b0; NextImage = 1'b0;
        step(); step(); step();
        chk("rst_x",   32'(x),          32'hfff);
        chk("rst_y",   32'(y),          32'hfff);
        chk("rst_de",  32'(DE),         32'd0);
        chk("rst_hs",  32'(HSync),      32'd0);
        chk("rst_vs",  32'(VSync),      32'd0);
        chk("rst_fs",  32'(FrameStart), 32'd0);
        chk("rst_img", 32'(ImageState), 32'h1);

        // First frame after reset, recorded cycle by cycle
        Reset = 1'b0;
        for (int c = 0; c < FRAME; c++) begin
            step();
            sx[c] = x; sy[c] = y; sde[c] = DE; shs[c] = HSync;
            svs[c] = VSync; sfs[c] = FrameStart; simg[c] = ImageState;
        end

        for (int i = 0; i < 16; i++) begin
            int c;
            c = tbl[i].cyc;
            chk($sformatf("tbl_x_c%0d", c),  32'(sx[c]),  32'(tbl[i].x));
            chk($sformatf("tbl_y_c%0d", c),  32'(sy[c]),  32'(tbl[i].y));
            chk($sformatf("tbl_de_c%0d", c), 32'(sde[c]), 32'(tbl[i].de));
            chk($sformatf("tbl_hs_c%0d", c), 32'(shs[c]), 32'(tbl[i].hs));
            chk($sformatf("tbl_vs_c%0d", c), 32'(svs[c]), 32'(tbl[i].vs));
            chk($sformatf("tbl_fs_c%0d", c), 32'(sfs[c]), 32'(tbl[i].fs));
        end

        de_n = 0; fs_n = 0; hs_n = 0; vs_n = 0; xsum = 0; ysum = 0;
        de_bad = 0; y_lead = 0; img_ok = 0;
        for (int c = 0; c < FRAME; c++) begin
            if (sde[c]) begin
                de_n++;
                xsum += int'(sx[c]);
                ysum += int'(sy[c]);
            end
            if (sde[c] != (sx[c] != 12'hfff)) de_bad++;
            if (sfs[c]) fs_n++;
            if (shs[c]) hs_n++;
            if (svs[c]) vs_n++;
            if (c >= 42 && c <= 47 && sy[c] == 12'h000 && sx[c] == 12'hfff) y_lead++;
            if (simg[c] == 4'b0001) img_ok++;
        end
        chk("f0_de_count", 32'(de_n),   32'd32);
        chk("f0_fs_count", 32'(fs_n),   32'd1);
        chk("f0_hs_count", 32'(hs_n),   32'd14);
        chk("f0_vs_count", 32'(vs_n),   32'd14);
        chk("f0_x_sum",    32'(xsum),   32'd112);
        chk("f0_y_sum",    32'(ysum),   32'd48);
        chk("f0_de_vs_x",  32'(de_bad), 32'd0);
        chk("f0_y_lead",   32'(y_lead), 32'd6);
        chk("f0_img",      32'(img_ok), 32'd98);

        // Free run: image rotates every two frames
        for (int f = 1; f <= 8; f++) begin
            run_frame($sformatf("free%0d", f), 1'b0, -1, -1, img);
            chk($sformatf("free%0d_img", f), 32'(img), 32'(free_exp[f]));
        end

        // Hold suppresses auto-advance; release advances at the next boundary
        run_frame("hold9", 1'b1, -1, -1, img);
        chk("hold9_img", 32'(img), 32'h1);
        run_frame("hold10", 1'b1, -1, -1, img);
        chk("hold10_img", 32'(img), 32'h1);
        run_frame("hold11", 1'b1, -1, -1, img);
        chk("hold11_img", 32'(img), 32'h1);
        run_frame("rel12", 1'b0, -1, -1, img);
        chk("rel12_img", 32'(img), 32'h1);

        // Mid-frame reset at hc=5, vc=4
        Hold = 1'b0;
        for (int k = 1; k <= 61; k++) step();
        chk("pre_rst_img", 32'(ImageState), 32'h2);
        chk("pre_rst_y",   32'(y),          32'h1);
        Reset = 1'b1;
        step();
        chk("mid_rst_x",   32'(x),          32'hfff);
        chk("mid_rst_y",   32'(y),          32'hfff);
        chk("mid_rst_de",  32'(DE),         32'd0);
        chk("mid_rst_hs",  32'(HSync),      32'd0);
        chk("mid_rst_vs",  32'(VSync),      32'd0);
        chk("mid_rst_img", 32'(ImageState), 32'h1);
        Reset = 1'b0;

        // Two requests in frame 0 give a single advance and restart fc
        run_frame("req0", 1'b0, 20, 50, img);
        chk("req0_img", 32'(img), 32'h1);
        run_frame("req1", 1'b0, -1, -1, img);
        chk("req1_img", 32'(img), 32'h2);
        run_frame("req2", 1'b0, -1, -1, img);
        chk("req2_img", 32'(img), 32'h2);
        // Request on the boundary cycle itself
        run_frame("req3", 1'b0, 98, -1, img);
        chk("req3_img", 32'(img), 32'h4);
        run_frame("req4", 1'b0, -1, -1, img);
        chk("req4_img", 32'(img), 32'h8);
        // Request coinciding with auto-advance: one step only
        run_frame("req5", 1'b0, 30, -1, img);
        chk("req5_img", 32'(img), 32'h8);
        run_frame("req6", 1'b0, -1, -1, img);
        chk("req6_img", 32'(img), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
